// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and accepted-key bundle between the scan controller and its
// surroundings. The master side is the scan controller itself; the slave side
// is the keypad matrix plus the downstream encoder.
interface keypad_scan_ctrl_if;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] key_onehot;
   logic        key_valid;
   logic        key_down;

   modport master (
      input  col_in,
      output row_out,
      output key_onehot,
      output key_valid,
      output key_down
   );

   modport slave (
      output col_in,
      input  row_out,
      input  key_onehot,
      input  key_valid,
      input  key_down
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row low per dwell, samples the
// synchronised columns at the end of each dwell, debounces whole 16-key
// sweeps and reports one key per press episode as a one-hot word.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no key accepted; waiting for a stable single-key sweep
//   ST_PRESSED | a key was reported; waiting for a stable all-released sweep
module keypad_scan_ctrl #(
   parameter int unsigned CLK_DIV  = 50000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_scan_ctrl_if.master kp
);

   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [3:0]       CNT_MAX  = 4'(DEBOUNCE - 1);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESSED = 1'b1
   } state_t;

   logic [3:0]       col_s1_q;
   logic [3:0]       col_s2_q;
   logic [DIV_W-1:0] div_q;
   logic             tick;
   logic [1:0]       row_q;
   logic [3:0]       pressed;
   logic [11:0]      acc_q;
   logic [15:0]      snap_q;
   logic             sweep_done_q;
   logic [15:0]      prev_q;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic             stable;
   logic             snap_one_hot;
   state_t           state_q;
   state_t           state_d;
   logic [15:0]      onehot_q;
   logic [15:0]      onehot_d;
   logic             valid_q;
   logic             valid_d;
   logic             down_q;
   logic             down_d;

   assign tick    = (div_q == DIV_LAST);
   assign pressed = ~col_s2_q;

   // Two-flop synchroniser for the asynchronous, active-low column lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s1_q <= 4'hF;
         col_s2_q <= 4'hF;
      end else begin
         col_s1_q <= kp.col_in;
         col_s2_q <= col_s1_q;
      end
   end

   // Row dwell divider; tick marks the last clock of each dwell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Sample the driven row on tick, advance the row and close the snapshot after row 3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q        <= 2'd0;
         acc_q        <= '0;
         snap_q       <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         sweep_done_q <= 1'b0;
         if (tick) begin
            row_q <= row_q + 2'd1;
            case (row_q)
               2'd0: acc_q[3:0]  <= pressed;
               2'd1: acc_q[7:4]  <= pressed;
               2'd2: acc_q[11:8] <= pressed;
               2'd3: begin
                  snap_q       <= {pressed, acc_q};
                  sweep_done_q <= 1'b1;
               end
               default: acc_q <= acc_q;
            endcase
         end
      end
   end

   // Count consecutive identical sweeps, saturating at the acceptance threshold.
   always_comb begin
      cnt_d = cnt_q;
      if (sweep_done_q) begin
         if (snap_q == prev_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
         end else begin
            cnt_d = 4'd0;
         end
      end
   end

   assign stable       = sweep_done_q && (cnt_d == CNT_MAX);
   assign snap_one_hot = (snap_q != 16'd0) && ((snap_q & (snap_q - 16'd1)) == 16'd0);

   // Debounce history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 4'd0;
         prev_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (sweep_done_q) begin
            prev_q <= snap_q;
         end
      end
   end

   // Press-episode state and registered key outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         onehot_q <= '0;
         valid_q  <= 1'b0;
         down_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         valid_q  <= valid_d;
         down_q   <= down_d;
      end
   end

   // Accept a lone key from idle; only a stable full release ends the episode.
   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      valid_d  = 1'b0;
      down_d   = down_q;
      if (stable) begin
         case (state_q)
            ST_IDLE: begin
               if (snap_one_hot) begin
                  state_d  = ST_PRESSED;
                  onehot_d = snap_q;
                  valid_d  = 1'b1;
                  down_d   = 1'b1;
               end
            end
            ST_PRESSED: begin
               if (snap_q == 16'd0) begin
                  state_d  = ST_IDLE;
                  onehot_d = '0;
                  down_d   = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign kp.row_out    = ~(4'b0001 << row_q);
   assign kp.key_onehot = onehot_q;
   assign kp.key_valid  = valid_q;
   assign kp.key_down   = down_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model driven by a per-sweep
// pressed-key vector, a sweep-level reference model of debounce and press
// episodes, and a per-cycle compare process.
module tb_keypad_scan_ctrl;
   localparam int CLK_DIV = 4;
   localparam int DEB     = 3;
   localparam int SWEEP   = 4 * CLK_DIV;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pressed = '0;
   logic [3:0]  kp_col;
   logic [15:0] snaps[$];

   int n_chk   = 0;
   int n_pass  = 0;
   int n_valid = 0;
   int cyc     = 0;

   logic [15:0] m_prev   = '0;
   logic [15:0] m_onehot = '0;
   logic        m_down   = 1'b0;
   logic        m_valid  = 1'b0;
   int          m_run    = 1;
   logic [15:0] s;
   logic [3:0]  m_row;
   logic [3:0]  row_one = 4'b0001;

   keypad_scan_ctrl_if kif ();

   keypad_scan_ctrl #(
      .CLK_DIV  (CLK_DIV),
      .DEBOUNCE (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kif)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      kp_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!kif.row_out[r]) kp_col = kp_col & ~pressed[r*4 +: 4];
      end
   end
   assign kif.col_in = kp_col;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: one update per completed sweep, evaluated on the clock
   // after that sweep's last sample; every other cycle checks held values.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_prev   = '0;
         m_onehot = '0;
         m_down   = 1'b0;
         m_valid  = 1'b0;
         m_run    = 1;
         check("rst_row_out", kif.row_out, 4'b1110);
         check("rst_key_onehot", kif.key_onehot, 16'h0000);
         check("rst_key_valid", kif.key_valid, 1'b0);
         check("rst_key_down", kif.key_down, 1'b0);
      end else begin
         m_valid = 1'b0;
         if (cyc > SWEEP && (cyc % SWEEP) == 1) begin
            if (snaps.size() == 0) begin
               check("sweep_queue", 0, 1);
            end else begin
               s = snaps.pop_front();
               if (s == m_prev) begin
                  if (m_run < 1000) m_run++;
               end else begin
                  m_run = 1;
               end
               m_prev = s;
               if (m_run >= DEB) begin
                  if (!m_down && $countones(s) == 1) begin
                     m_onehot = s;
                     m_down   = 1'b1;
                     m_valid  = 1'b1;
                  end else if (m_down && s == 16'h0000) begin
                     m_onehot = '0;
                     m_down   = 1'b0;
                  end
               end
            end
         end
         m_row = ~(row_one << ((cyc / CLK_DIV) % 4));
         check("row_out", kif.row_out, m_row);
         check("key_onehot", kif.key_onehot, m_onehot);
         check("key_valid", kif.key_valid, m_valid);
         check("key_down", kif.key_down, m_down);
         if (kif.key_valid) n_valid++;
      end
   end

   task automatic sweep(input logic [15:0] p);
      pressed = p;
      snaps.push_back(p);
      repeat (SWEEP) @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [15:0] p, input int n);
      repeat (n) sweep(p);
   endtask

   // Checks the outcome of the sweep just finished, then performs sweep p.
   task automatic chk_sweep(input string tag, input logic [15:0] p, input logic ev,
                            input logic [15:0] eo, input logic ed);
      pressed = p;
      snaps.push_back(p);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, kif.key_valid, ev);
      check({tag, "_onehot"}, kif.key_onehot, eo);
      check({tag, "_down"}, kif.key_down, ed);
      repeat (SWEEP - 1) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int          v0;
      int          r;
      int          a;
      int          b;
      logic [15:0] cur;
      logic [15:0] one;
      one = 16'h0001;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_row", kif.row_out, 4'b1110);
      check("reset_onehot", kif.key_onehot, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      run(16'h0000, 2);

      // Single press of key 9 (row 2, col 1) and its release.
      v0 = n_valid;
      run(16'h0200, 3);
      chk_sweep("press", 16'h0200, 1'b1, 16'h0200, 1'b1);
      chk_sweep("held", 16'h0200, 1'b0, 16'h0200, 1'b1);
      run(16'h0000, 2);
      chk_sweep("rel_wait", 16'h0000, 1'b0, 16'h0200, 1'b1);
      chk_sweep("release", 16'h0000, 1'b0, 16'h0000, 1'b0);
      check("press_count", n_valid - v0, 1);

      // Bounce on key 0.
      v0 = n_valid;
      run(16'h0001, 1);
      run(16'h0000, 1);
      run(16'h0001, 1);
      run(16'h0000, 1);
      run(16'h0001, 2);
      chk_sweep("bounce_wait", 16'h0001, 1'b0, 16'h0000, 1'b0);
      chk_sweep("bounce_acc", 16'h0001, 1'b1, 16'h0001, 1'b1);
      run(16'h0000, 3);
      chk_sweep("bounce_rel", 16'h0000, 1'b0, 16'h0000, 1'b0);
      check("bounce_count", n_valid - v0, 1);

      // Chord of keys 0 and 5 rejected, then key 15 alone.
      v0 = n_valid;
      run(16'h0021, 4);
      chk_sweep("chord", 16'h0000, 1'b0, 16'h0000, 1'b0);
      check("chord_count", n_valid - v0, 0);
      run(16'h0000, 2);
      run(16'h8000, 3);
      chk_sweep("k15", 16'h8000, 1'b1, 16'h8000, 1'b1);
      run(16'h0000, 3);
      chk_sweep("k15_rel", 16'h0000, 1'b0, 16'h0000, 1'b0);

      // Rollover: key 9 held, key 3 added, key 9 released.
      v0 = n_valid;
      run(16'h0200, 3);
      chk_sweep("roll_acc", 16'h0208, 1'b1, 16'h0200, 1'b1);
      run(16'h0208, 2);
      run(16'h0008, 3);
      chk_sweep("roll_hold", 16'h0008, 1'b0, 16'h0200, 1'b1);
      run(16'h0000, 3);
      chk_sweep("roll_rel", 16'h0000, 1'b0, 16'h0000, 1'b0);
      run(16'h0008, 3);
      chk_sweep("roll_k3", 16'h0008, 1'b1, 16'h0008, 1'b1);
      run(16'h0000, 3);
      chk_sweep("roll_k3rel", 16'h0000, 1'b0, 16'h0000, 1'b0);
      check("roll_count", n_valid - v0, 2);

      // Reset in the middle of a sweep while key 9 is accepted.
      run(16'h0200, 3);
      chk_sweep("rst_pre", 16'h0200, 1'b1, 16'h0200, 1'b1);
      pressed = 16'h0200;
      snaps.push_back(16'h0200);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_row", kif.row_out, 4'b1110);
      check("midrst_onehot", kif.key_onehot, 16'h0000);
      check("midrst_valid", kif.key_valid, 1'b0);
      check("midrst_down", kif.key_down, 1'b0);
      repeat (3) @(posedge clk);
      snaps.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run(16'h0200, 3);
      chk_sweep("rst_post", 16'h0200, 1'b1, 16'h0200, 1'b1);
      run(16'h0000, 3);
      chk_sweep("rst_rel", 16'h0000, 1'b0, 16'h0000, 1'b0);

      // Random sweep patterns, mostly repeats so episodes get accepted.
      cur = 16'h0000;
      repeat (80) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            cur = cur;
         end else if (r <= 6) begin
            cur = 16'h0000;
         end else if (r <= 8) begin
            cur = one << $urandom_range(0, 15);
         end else begin
            a   = $urandom_range(0, 15);
            b   = $urandom_range(0, 15);
            cur = (one << a) | (one << b);
         end
         sweep(cur);
      end
      run(16'h0000, 3);
      chk_sweep("final_rel", 16'h0000, 1'b0, 16'h0000, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It drives one row low at a time and samples the four column lines. It debounces complete 16-key sweeps and publishes a single accepted key as a 16-bit one-hot word with a one-cycle valid strobe. It sits between the keypad pins and the downstream one-hot-to-binary encoder, and supplies that encoder's `onehot` input.

## Interface
- `CLK_DIV`, default 50000: clocks per row dwell (scan tick period); legal range 4 to 2^20.
- `DEBOUNCE`, default 4: number of consecutive identical sweeps required to accept a snapshot; legal range 2 to 15.
- `clk` input 1: single system clock; all logic rises on its positive edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `col_in` input 4: keypad columns; active-low, pulled up externally, asynchronous to `clk`.
- `row_out` output 4: keypad rows; exactly one bit low (driven row), others high.
- `key_onehot` output 16: accepted key, bit index = row*4 + col; all zero when no key is accepted.
- `key_valid` output 1: one-clk pulse when a new key is accepted.
- `key_down` output 1: level, high while an accepted key remains held.

## Operation
- Synchroniser: `col_in` passes through two flops. Only the synchronised value is sampled.
- Divider: counter runs 0..CLK_DIV-1. `tick` is high on the cycle where count = CLK_DIV-1, then the counter wraps to 0.
- Row sequencer: 2-bit index r, `row_out = ~(4'b0001 << r)`.
  - On a tick edge, columns of row r are sampled, then r advances (3 wraps to 0).
  - Pressed bit for (r, j) = ~sync_col[j].
- Sweep: the tick that samples r = 3 completes a 16-bit snapshot and raises internal `sweep_done` for one cycle.
- Debounce, evaluated on `sweep_done`:
  - If snap == prev, cnt <= min(cnt+1, DEBOUNCE-1); otherwise cnt <= 0.
  - prev <= snap.
  - `stable` = (updated cnt == DEBOUNCE-1).
- FSM, two states, acts only on a cycle with `sweep_done && stable`:
  - IDLE: if the snapshot has exactly one bit set, go to PRESSED, load `key_onehot` = snapshot, pulse `key_valid`, set `key_down`. A zero or multi-bit snapshot leaves the FSM in IDLE with no output change.
  - PRESSED: if the snapshot is all zero, go to IDLE, clear `key_onehot` and `key_down`. Any nonzero snapshot (same key, added keys, or a different key) keeps PRESSED with outputs unchanged; no new event fires until a stable full release.
- Rollover: only one key per press episode is reported. Multi-key chords pressed from IDLE are rejected entirely.

## Timing
- Reset values, applied asynchronously while `rst_n` = 0:
  - `row_out` = 4'b1110, r = 0, divider = 0.
  - `key_onehot` = 0, `key_valid` = 0, `key_down` = 0.
  - FSM = IDLE, prev = 0, cnt = 0, synchroniser flops = 4'hF.
- Reset mid-operation: every output returns to its reset value immediately, and any partial sweep is discarded. After release, the first tick occurs CLK_DIV clocks later.
- Row dwell: each row is driven for CLK_DIV clocks, and a full sweep takes 4*CLK_DIV clocks. The sample is taken at the end of the dwell, so a CLK_DIV of at least 4 covers the 2-flop sync plus 1 clock of settle.
- Accept latency: a key held from the start of a sweep is accepted at the end of its DEBOUNCE-th sweep. `key_valid`, `key_onehot` and `key_down` update on the clock edge after the sampling edge of row 3, so `key_valid` is high for exactly one clock.
- Release latency: `key_down` and `key_onehot` clear DEBOUNCE sweeps after a clean release, with the same one-clock offset.
- A snapshot change of any bit resets cnt to 0, which restarts debounce.
- Downstream: the encoder registers again, so the binary code is valid one clock after `key_valid`.

## Test plan
All scenarios use CLK_DIV=4 and DEBOUNCE=3.
- Reset and scan: assert `rst_n` low, then release it. Required: `row_out` = 1110, `key_onehot` = 0, `key_valid` = 0, `key_down` = 0. After release, `row_out` steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every 4 clks, with no `key_valid`.
- Single press: model key (row 2, col 1) by pulling `col_in[1]` low while `row_out[2]` = 0, held from a sweep start. Required: one `key_valid` pulse 48+1 clks later, `key_onehot` = 16'h0200, `key_down` = 1, and no further pulses while held. On release, `key_onehot` = 0 and `key_down` = 0 after 3 sweeps.
- Bounce: key 0 alternates pressed/released on successive sweeps for 4 sweeps, then stays held. Required: exactly one `key_valid`, 3 sweeps after bouncing stops, with `key_onehot` = 16'h0001.
- Chord: keys 0 and 5 pressed together from IDLE. Required: no `key_valid`, `key_down` = 0, `key_onehot` = 0. Release both, then press key 15 alone. Required: `key_onehot` = 16'h8000 and one pulse.
- Rollover: key 9 is held (accepted, `key_onehot` = 16'h0200), then key 3 is added and key 9 is released. Required: no new `key_valid` and `key_onehot` stays 16'h0200. After a full release and 3 sweeps, IDLE is reached. Pressing key 3 again then yields 16'h0008.
- Reset mid-press: assert `rst_n` while key 9 is accepted. Required: outputs clear in the same cycle. Release reset with key 9 still held. Required: a new `key_valid` with 16'h0200 after 3 sweeps.
